// File: rtl/rx_logic.sv
// Serial receive front end: samples SSPCLKIN/SSPFSSIN/SSPRXD in the PCLK domain and assembles 8-bit MSB-first frames.
// Define RX_INPUT_SYNC_EN to insert 2-flop input synchronizers (adds 2 cycles of latency).
module rx_logic (
    input  logic       PCLK,
    input  logic       CLEAR,
    input  logic       SSPCLKIN,
    input  logic       SSPFSSIN,
    input  logic       SSPRXD,
    input  logic       SSPRXINTR,
    input  logic       ovr_clr,
    output logic [7:0] RxData,
    output logic       rx_ready,
    output logic       rx_overrun
);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic clk_s2;
    logic fss_s2;
    logic rxd_s2;
    logic clk_s3;
    logic sample_en;

`ifdef RX_INPUT_SYNC_EN
    logic clk_s1_reg, fss_s1_reg, rxd_s1_reg;
    logic clk_s2_reg, fss_s2_reg, rxd_s2_reg;
    logic clk_s3_reg;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            clk_s1_reg <= 1'b0;
            fss_s1_reg <= 1'b0;
            rxd_s1_reg <= 1'b0;
            clk_s2_reg <= 1'b0;
            fss_s2_reg <= 1'b0;
            rxd_s2_reg <= 1'b0;
            clk_s3_reg <= 1'b0;
        end else begin
            clk_s1_reg <= SSPCLKIN;
            fss_s1_reg <= SSPFSSIN;
            rxd_s1_reg <= SSPRXD;
            clk_s2_reg <= clk_s1_reg;
            fss_s2_reg <= fss_s1_reg;
            rxd_s2_reg <= rxd_s1_reg;
            clk_s3_reg <= clk_s2_reg;
        end
    end

    assign clk_s2 = clk_s2_reg;
    assign fss_s2 = fss_s2_reg;
    assign rxd_s2 = rxd_s2_reg;
    assign clk_s3 = clk_s3_reg;
`else
    // Pins are already PCLK-synchronous; only the clock needs a delayed copy for edge detection.
    logic clk_d_reg;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) clk_d_reg <= 1'b0;
        else       clk_d_reg <= SSPCLKIN;
    end

    assign clk_s2 = SSPCLKIN;
    assign fss_s2 = SSPFSSIN;
    assign rxd_s2 = SSPRXD;
    assign clk_s3 = clk_d_reg;
`endif

    assign sample_en = clk_s3 & ~clk_s2;

    state_t     state_reg;
    logic [2:0] bitcnt_reg;
    // Only the first seven bits are held; the eighth comes straight from rxd on the completing edge.
    logic [6:0] shreg_reg;
    logic       pend_reg;
    logic       pend_d_reg;
    logic       word_done;

    assign word_done = sample_en && (state_reg == SHIFT) && (bitcnt_reg == 3'd7);

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_reg  <= IDLE;
            bitcnt_reg <= 3'd0;
            shreg_reg  <= 7'd0;
            pend_reg   <= 1'b0;
            pend_d_reg <= 1'b0;
            RxData     <= 8'h00;
            rx_ready   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            pend_reg   <= 1'b0;
            pend_d_reg <= pend_reg;
            // Two-cycle strobe, starting the cycle after RxData updates.
            rx_ready   <= pend_reg | pend_d_reg;

            if (sample_en) begin
                case (state_reg)
                    IDLE: begin
                        if (fss_s2) begin
                            state_reg  <= SHIFT;
                            bitcnt_reg <= 3'd0;
                        end
                    end
                    SHIFT: begin
                        shreg_reg <= {shreg_reg[5:0], rxd_s2};
                        if (bitcnt_reg == 3'd7) begin
                            bitcnt_reg <= 3'd0;
                            state_reg  <= fss_s2 ? SHIFT : IDLE;
                            if (!SSPRXINTR) begin
                                RxData   <= {shreg_reg, rxd_s2};
                                pend_reg <= 1'b1;
                            end
                        end else begin
                            bitcnt_reg <= bitcnt_reg + 3'd1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end

            if (word_done && SSPRXINTR) rx_overrun <= 1'b1;
            else if (ovr_clr)           rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_logic.sv
// Directed testbench for rx_logic: drives serial frames at PCLK/12 and checks data, strobe timing and overrun.
module tb_rx_logic;

`ifdef RX_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       PCLK = 1'b0;
    logic       CLEAR = 1'b1;
    logic       SSPCLKIN = 1'b0;
    logic       SSPFSSIN = 1'b0;
    logic       SSPRXD = 1'b0;
    logic       SSPRXINTR = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] RxData;
    logic       rx_ready;
    logic       rx_overrun;

    rx_logic dut (
        .PCLK      (PCLK),
        .CLEAR     (CLEAR),
        .SSPCLKIN  (SSPCLKIN),
        .SSPFSSIN  (SSPFSSIN),
        .SSPRXD    (SSPRXD),
        .SSPRXINTR (SSPRXINTR),
        .ovr_clr   (ovr_clr),
        .RxData    (RxData),
        .rx_ready  (rx_ready),
        .rx_overrun(rx_overrun)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_k = 0;

    // Observation state, sampled 1 time unit after each rising PCLK edge.
    int         pulse_cnt = 0;
    int         last_rise = -1;
    int         last_len  = -1;
    int         last_chg  = -1;
    int         run_len   = 0;
    logic       prev_rdy  = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] caps[$];

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(posedge PCLK) begin
        #1;
        if (rx_ready && !prev_rdy) begin
            pulse_cnt++;
            last_rise = cyc;
            run_len = 0;
            caps.push_back(RxData);
        end
        if (rx_ready) run_len++;
        else if (prev_rdy) last_len = run_len;
        if (RxData != prev_data) last_chg = cyc;
        prev_rdy = rx_ready;
        prev_data = RxData;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One serial-clock period: rise with new data/fss, 6 cycles high, fall (sampled), 6 cycles low.
    task automatic serial_bit(input logic f, input logic d);
        @(negedge PCLK);
        SSPCLKIN = 1'b1;
        SSPFSSIN = f;
        SSPRXD   = d;
        repeat (6) @(negedge PCLK);
        SSPCLKIN = 1'b0;
        last_k = cyc + 1;
        repeat (5) @(negedge PCLK);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic lead_fss,
                              input logic fss_last, input logic [7:0] glitch);
        if (lead_fss) serial_bit(1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            serial_bit((i == 7) ? fss_last : glitch[i], w[7-i]);
        SSPFSSIN = 1'b0;
    endtask

    task automatic settle();
        repeat (5) @(negedge PCLK);
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_chg"},  last_chg,  last_k + LAT);
        check({tag, "_rise"}, last_rise, last_k + LAT + 1);
        check({tag, "_len"},  last_len,  2);
    endtask

    int p0;

    initial begin
        repeat (3) @(negedge PCLK);
        check("rst_data", RxData, 8'h00);
        check("rst_ready", rx_ready, 1'b0);
        check("rst_ovr", rx_overrun, 1'b0);
        CLEAR = 1'b0;
        repeat (3) @(negedge PCLK);

        // Single frame 0xA5
        p0 = pulse_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 8'h00);
        settle();
        check("a5_data", RxData, 8'hA5);
        check("a5_pulses", pulse_cnt - p0, 1);
        check("a5_ovr", rx_overrun, 1'b0);
        check_timing("a5");
        $display("[TB] frame 0xA5: RxData=%02h rise=%0d k=%0d", RxData, last_rise, last_k);

        // Back-to-back 0x3C then 0xC3, FSS on the last bit of the first
        p0 = pulse_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 8'h00);
        send_frame(8'hC3, 1'b0, 1'b0, 8'h00);
        settle();
        check("b2b_pulses", pulse_cnt - p0, 2);
        check("b2b_first", caps[p0], 8'h3C);
        check("b2b_second", caps[p0 + 1], 8'hC3);
        check_timing("b2b");
        $display("[TB] back-to-back: %02h %02h", caps[p0], caps[p0 + 1]);

        // Overrun: 0x12 accepted, then 0x55 dropped while FIFO is full
        send_frame(8'h12, 1'b1, 1'b0, 8'h00);
        settle();
        check("pre_ovr_data", RxData, 8'h12);
        p0 = pulse_cnt;
        SSPRXINTR = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0, 8'h00);
        settle();
        SSPRXINTR = 1'b0;
        check("ovr_data", RxData, 8'h12);
        check("ovr_pulses", pulse_cnt - p0, 0);
        check("ovr_set", rx_overrun, 1'b1);
        @(negedge PCLK);
        check("ovr_held", rx_overrun, 1'b1);
        ovr_clr = 1'b1;
        @(negedge PCLK);
        ovr_clr = 1'b0;
        @(negedge PCLK);
        check("ovr_clr", rx_overrun, 1'b0);
        $display("[TB] overrun frame 0x55: RxData=%02h", RxData);

        // CLEAR after 4 bits of a frame
        p0 = pulse_cnt;
        serial_bit(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) serial_bit(1'b0, 1'b1);
        @(negedge PCLK);
        CLEAR = 1'b1;
        #1;
        check("clr_data", RxData, 8'h00);
        check("clr_ready", rx_ready, 1'b0);
        check("clr_ovr", rx_overrun, 1'b0);
        repeat (3) @(negedge PCLK);
        CLEAR = 1'b0;
        repeat (10) @(negedge PCLK);
        check("clr_pulses", pulse_cnt - p0, 0);
        send_frame(8'h81, 1'b1, 1'b0, 8'h00);
        settle();
        check("clr_next_data", RxData, 8'h81);
        check_timing("x81");
        $display("[TB] after CLEAR frame 0x81: RxData=%02h", RxData);

        // 20 idle edges, then 0xF0 with FSS glitches at bits 2 and 5
        p0 = pulse_cnt;
        for (int i = 0; i < 20; i++) serial_bit(1'b0, i[0]);
        check("idle_pulses", pulse_cnt - p0, 0);
        check("idle_data", RxData, 8'h81);
        send_frame(8'hF0, 1'b1, 1'b0, 8'b0010_0100);
        settle();
        check("glitch_data", RxData, 8'hF0);
        check("glitch_pulses", pulse_cnt - p0, 1);
        $display("[TB] glitch frame 0xF0: RxData=%02h", RxData);

        // Frame 0x7E latency
        send_frame(8'h7E, 1'b1, 1'b0, 8'h00);
        settle();
        check("x7e_data", RxData, 8'h7E);
        check_timing("x7e");
        $display("[TB] frame 0x7E: RxData=%02h rise=%0d k=%0d", RxData, last_rise, last_k);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
